// File: rtl/jtag_tap_core.sv
// -----------------------------------------------------------------------------
// jtag_tap_core
//
// IEEE 1149.1 Test Access Port controller. It contains the 16-state TAP FSM,
// an instruction register, and three data registers: BYPASS (1 bit),
// IDCODE (32 bits, optional) and a USER register (DR_WIDTH bits) with
// parallel capture and update.
//
// Build option:
//   JTAG_TAP_IDCODE_EN  - when defined, the IDCODE instruction (opcode 1) and
//                         its 32-bit register are present, and IDCODE is the
//                         reset instruction. When undefined, opcode 1 decodes
//                         as BYPASS and the reset instruction is all ones.
//
// Ports:
//   TCK     in   sole clock; every state change happens on its rising edge
//   rst     in   synchronous active-high reset
//   TMS     in   test mode select
//   TDI     in   serial data in
//   TDO     out  serial data out (combinational from the shift registers)
//   state   out  current TAP state code
//   ir_o    out  active (updated) instruction
//   dr_i    in   parallel value captured into the USER register
//   dr_o    out  USER register value latched at Update-DR
//   dr_upd  out  one-cycle pulse while dr_o is being written
// -----------------------------------------------------------------------------
module jtag_tap_core #(
    parameter int          IR_WIDTH   = 4,
    parameter int          DR_WIDTH   = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1AB0_0001,
    parameter int          USER_OP    = 2
) (
    input  logic                TCK,
    input  logic                rst,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic [3:0]          state,
    output logic [IR_WIDTH-1:0] ir_o,
    input  logic [DR_WIDTH-1:0] dr_i,
    output logic [DR_WIDTH-1:0] dr_o,
    output logic                dr_upd
);

    localparam logic [3:0] S_TLR   = 4'hF;
    localparam logic [3:0] S_RTI   = 4'hC;
    localparam logic [3:0] S_SELDR = 4'h7;
    localparam logic [3:0] S_CAPDR = 4'h6;
    localparam logic [3:0] S_SHDR  = 4'h2;
    localparam logic [3:0] S_EX1DR = 4'h1;
    localparam logic [3:0] S_PAUDR = 4'h3;
    localparam logic [3:0] S_EX2DR = 4'h0;
    localparam logic [3:0] S_UPDDR = 4'h5;
    localparam logic [3:0] S_SELIR = 4'h4;
    localparam logic [3:0] S_CAPIR = 4'hE;
    localparam logic [3:0] S_SHIR  = 4'hA;
    localparam logic [3:0] S_EX1IR = 4'h9;
    localparam logic [3:0] S_PAUIR = 4'hB;
    localparam logic [3:0] S_EX2IR = 4'h8;
    localparam logic [3:0] S_UPDIR = 4'hD;

    // Fixed capture pattern: bit0=1, bit1=0 lets a host verify chain length.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_DEFAULT = IR_WIDTH'(1);
`else
    localparam logic [IR_WIDTH-1:0] IR_DEFAULT = '1;
`endif

    logic [3:0]          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_sr_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic                bypass_q;
    logic [DR_WIDTH-1:0] user_sr_q;
    logic [DR_WIDTH-1:0] dr_q;
    logic                sel_user;
    logic                sel_bypass;
`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0]         idcode_sr_q;
    logic                sel_idcode;
`endif

    // Instruction decode. All ones always means BYPASS, as do unknown opcodes.
    always_comb begin
        sel_user   = 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
        sel_idcode = 1'b0;
`endif
        if (ir_q == '1) begin
            sel_user = 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
        end else if (ir_q == IR_WIDTH'(1)) begin
            sel_idcode = 1'b1;
`endif
        end else if (ir_q == IR_WIDTH'(USER_OP)) begin
            sel_user = 1'b1;
        end
`ifdef JTAG_TAP_IDCODE_EN
        sel_bypass = ~sel_user & ~sel_idcode;
`else
        sel_bypass = ~sel_user;
`endif
    end

    // TAP state register
    always_ff @(posedge TCK) begin
        if (rst) begin
            state_q <= S_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // TAP next-state logic (IEEE 1149.1 TMS graph)
    always_comb begin
        state_d = S_TLR;
        case (state_q)
            S_TLR:   state_d = TMS ? S_TLR   : S_RTI;
            S_RTI:   state_d = TMS ? S_SELDR : S_RTI;
            S_SELDR: state_d = TMS ? S_SELIR : S_CAPDR;
            S_CAPDR: state_d = TMS ? S_EX1DR : S_SHDR;
            S_SHDR:  state_d = TMS ? S_EX1DR : S_SHDR;
            S_EX1DR: state_d = TMS ? S_UPDDR : S_PAUDR;
            S_PAUDR: state_d = TMS ? S_EX2DR : S_PAUDR;
            S_EX2DR: state_d = TMS ? S_UPDDR : S_SHDR;
            S_UPDDR: state_d = TMS ? S_SELDR : S_RTI;
            S_SELIR: state_d = TMS ? S_TLR   : S_CAPIR;
            S_CAPIR: state_d = TMS ? S_EX1IR : S_SHIR;
            S_SHIR:  state_d = TMS ? S_EX1IR : S_SHIR;
            S_EX1IR: state_d = TMS ? S_UPDIR : S_PAUIR;
            S_PAUIR: state_d = TMS ? S_EX2IR : S_PAUIR;
            S_EX2IR: state_d = TMS ? S_UPDIR : S_SHIR;
            S_UPDIR: state_d = TMS ? S_SELDR : S_RTI;
            default: state_d = S_TLR;
        endcase
    end

    // TAP outputs
    always_comb begin
        state  = state_q;
        dr_upd = (state_q == S_UPDDR) && sel_user && !rst;
        TDO    = 1'b0;
        if (state_q == S_SHIR) begin
            TDO = ir_sr_q[0];
        end else if (state_q == S_SHDR) begin
            if (sel_user) begin
                TDO = user_sr_q[0];
`ifdef JTAG_TAP_IDCODE_EN
            end else if (sel_idcode) begin
                TDO = idcode_sr_q[0];
`endif
            end else begin
                TDO = bypass_q;
            end
        end
    end

    // Shift registers: capture, shift right with TDI into the MSB, hold otherwise
    always_ff @(posedge TCK) begin
        if (rst) begin
            ir_sr_q     <= '0;
            bypass_q    <= 1'b0;
            user_sr_q   <= '0;
`ifdef JTAG_TAP_IDCODE_EN
            idcode_sr_q <= '0;
`endif
        end else begin
            case (state_q)
                S_CAPIR: ir_sr_q <= IR_CAPTURE;
                S_SHIR:  ir_sr_q <= {TDI, ir_sr_q[IR_WIDTH-1:1]};
                S_CAPDR: begin
                    if (sel_bypass) bypass_q <= 1'b0;
                    if (sel_user)   user_sr_q <= dr_i;
`ifdef JTAG_TAP_IDCODE_EN
                    if (sel_idcode) idcode_sr_q <= IDCODE_VAL;
`endif
                end
                S_SHDR: begin
                    if (sel_bypass) bypass_q <= TDI;
                    // Cast form keeps this legal for a 1-bit user register.
                    if (sel_user)   user_sr_q <= DR_WIDTH'({TDI, user_sr_q} >> 1);
`ifdef JTAG_TAP_IDCODE_EN
                    if (sel_idcode) idcode_sr_q <= {TDI, idcode_sr_q[31:1]};
`endif
                end
                default: ;
            endcase
        end
    end

    // Update registers. Entering TLR by any path restores the default
    // instruction, so it is already valid in the first TLR cycle.
    always_ff @(posedge TCK) begin
        if (rst) begin
            ir_q <= IR_DEFAULT;
            dr_q <= '0;
        end else begin
            if (state_d == S_TLR) begin
                ir_q <= IR_DEFAULT;
            end else if (state_q == S_UPDIR) begin
                ir_q <= ir_sr_q;
            end
            if (state_q == S_UPDDR && sel_user) begin
                dr_q <= user_sr_q;
            end
        end
    end

    assign ir_o = ir_q;
    assign dr_o = dr_q;

endmodule
